// File: rtl/gfx_host_bridge.sv
// gfx_host_bridge: turns valid/ready register commands into cs/rs/wren/data bus cycles on a generated bus clock.
// Define GFX_BRIDGE_PUTCHAR_EN to expand op 10 (putchar) into three back-to-back register writes.
module gfx_host_bridge #(
    parameter int HALF_PERIOD = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_rs,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_addr,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        err,
    output logic        busy,
    output logic        bus_clk,
    output logic        bus_cs_n,
    output logic [3:0]  bus_rs,
    output logic        bus_wren_n,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe,
    input  logic [7:0]  bus_data_i
);
    localparam int W = $clog2(2 * HALF_PERIOD);
    localparam logic [W-1:0] PH_RISE = W'(HALF_PERIOD - 1);
    localparam logic [W-1:0] PH_LAST = W'(2 * HALF_PERIOD - 1);
`ifdef GFX_BRIDGE_PUTCHAR_EN
    localparam bit PUT_EN = 1'b1;
`else
    localparam bit PUT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, CYCLE} state_t;
    state_t state, state_nx;

    logic [W-1:0] ph;
    logic         full, rd, launch, accept, illegal, put, last;
    logic [1:0]   h_op, step;
    logic [3:0]   h_rs, rs_nx;
    logic [7:0]   h_data, data_nx;
    logic [15:0]  h_addr;
    logic         cs_nx, wren_nx, oe_nx;

    // ph==0 is the first clk after the bus_clk fall; its closing edge is the launch tick
    assign launch    = ph == '0;
    assign cmd_ready = !full;
    assign accept    = cmd_valid && !full;
    assign illegal   = cmd_op == 2'b11 || (cmd_op == 2'b10 && !PUT_EN);
    assign put       = PUT_EN && h_op == 2'b10;
    assign last      = !put || step == 2'd2;
    assign busy      = full || state == CYCLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb state_nx = launch ? (full ? CYCLE : IDLE) : state;

    always_comb begin
        cs_nx   = bus_cs_n;
        wren_nx = bus_wren_n;
        oe_nx   = bus_data_oe;
        rs_nx   = bus_rs;
        data_nx = bus_data_o;
        if (launch && full) begin
            cs_nx   = 1'b0;
            wren_nx = h_op == 2'b01;
            oe_nx   = h_op != 2'b01;
            rs_nx   = !put ? h_rs : step == 2'd0 ? 4'd3 : step == 2'd1 ? 4'd4 : 4'd1;
            data_nx = last ? h_data : step == 2'd0 ? h_addr[7:0] : h_addr[15:8];
        end else if (launch) begin
            cs_nx   = 1'b1;
            wren_nx = 1'b1;
            oe_nx   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ph          <= '0;
            bus_clk     <= 1'b0;
            bus_cs_n    <= 1'b1;
            bus_wren_n  <= 1'b1;
            bus_rs      <= '0;
            bus_data_o  <= '0;
            bus_data_oe <= 1'b0;
            full        <= 1'b0;
            h_op        <= '0;
            h_rs        <= '0;
            h_data      <= '0;
            h_addr      <= '0;
            step        <= '0;
            rd          <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            err         <= 1'b0;
        end else begin
            ph          <= ph == PH_LAST ? '0 : ph + 1'b1;
            bus_clk     <= ph == PH_RISE ? 1'b1 : ph == PH_LAST ? 1'b0 : bus_clk;
            bus_cs_n    <= cs_nx;
            bus_wren_n  <= wren_nx;
            bus_rs      <= rs_nx;
            bus_data_o  <= data_nx;
            bus_data_oe <= oe_nx;
            err         <= accept && illegal;
            rsp_valid   <= rd && ph == PH_LAST;
            if (rd && ph == PH_LAST) rsp_data <= bus_data_i;
            if (launch) rd <= full && h_op == 2'b01;
            if (launch && full) step <= last ? 2'd0 : step + 2'd1;
            if (accept && !illegal) begin
                full   <= 1'b1;
                h_op   <= cmd_op;
                h_rs   <= cmd_rs;
                h_data <= cmd_data;
                h_addr <= cmd_addr;
            end else if (launch && full && last) begin
                full <= 1'b0;
            end
        end
endmodule

// File: tb/tb_gfx_host_bridge.sv
// tb_gfx_host_bridge: table vectors, directed corner sequences and random commands
// checked by a transaction-level bus model (HALF_PERIOD=4).
module tb_gfx_host_bridge;
    localparam int HP = 4;
    localparam int P  = 2 * HP;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_rs = '0;
    logic [7:0]  cmd_data = '0;
    logic [15:0] cmd_addr = '0;
    logic        rsp_valid, err, busy, bus_clk, bus_cs_n, bus_wren_n, bus_data_oe;
    logic [7:0]  rsp_data, bus_data_o;
    logic [7:0]  bus_data_i = '0;
    logic [3:0]  bus_rs;

    gfx_host_bridge #(.HALF_PERIOD(HP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_addr(cmd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .busy(busy),
        .bus_clk(bus_clk), .bus_cs_n(bus_cs_n), .bus_rs(bus_rs), .bus_wren_n(bus_wren_n),
        .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe), .bus_data_i(bus_data_i)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // clk edges since reset release; bus phase is k mod P
    int k = 0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else        k <= k + 1;

    typedef struct {
        logic [3:0] rs;
        logic       wren_n;
        logic [7:0] data;
        logic       oe;
        logic       rd;
        int         acc_k;
    } xfer_t;

    xfer_t       q[$];
    xfer_t       it;
    logic [14:0] prev, cur;
    logic        rd_pending = 1'b0, err_flag = 1'b0, active = 1'b0, go;
    logic [7:0]  rd_val = '0;
    int          fixed_din = -1;
    int          n_launch = 0, n_err = 0, n_rsp = 0;
    logic [7:0]  last_rsp = '0;

    task automatic push(input logic [3:0] rs, input logic wn, input logic [7:0] d, input logic rdx);
        q.push_back('{rs: rs, wren_n: wn, data: d, oe: !wn, rd: rdx, acc_k: k});
    endtask

    // Model and monitor: sampled on the falling clk edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("reset_outputs",
                32'({bus_clk, bus_cs_n, bus_wren_n, bus_rs, bus_data_o, bus_data_oe, rsp_valid, rsp_data, err, cmd_ready, busy}),
                32'({1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}));
            q.delete();
            rd_pending = 1'b0;
            err_flag   = 1'b0;
            active     = 1'b0;
            prev       = {1'b1, 1'b1, 4'h0, 8'h00, 1'b0};
        end else begin
            cur = {bus_cs_n, bus_wren_n, bus_rs, bus_data_o, bus_data_oe};
            chk("bus_clk", 32'(bus_clk), 32'((k % P) >= HP));
            if (k % P != 1) begin
                chk("bus_hold", 32'(cur), 32'(prev));
            end else begin
                go = q.size() != 0 && q[0].acc_k + 1 < k;
                chk("cs_n_launch", 32'(bus_cs_n), 32'(!go));
                if (!bus_cs_n) n_launch++;
                if (go) begin
                    it = q.pop_front();
                    chk("bus_rs", 32'(bus_rs), 32'(it.rs));
                    chk("bus_wren_n", 32'(bus_wren_n), 32'(it.wren_n));
                    chk("bus_oe", 32'(bus_data_oe), 32'(it.oe));
                    if (!it.rd) chk("bus_data_o", 32'(bus_data_o), 32'(it.data));
                end
                rd_pending = go && it.rd;
                active     = go;
            end
            prev = cur;
            if (k % P == HP) begin
                bus_data_i = fixed_din >= 0 ? 8'(fixed_din) : 8'($urandom);
                rd_val     = bus_data_i;
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(k % P == 0 && rd_pending));
            if (k % P == 0 && rd_pending) begin
                chk("rsp_data", 32'(rsp_data), 32'(rd_val));
                rd_pending = 1'b0;
            end
            if (rsp_valid) begin
                n_rsp++;
                last_rsp = rsp_data;
            end
            if (err) n_err++;
            chk("err", 32'(err), 32'(err_flag));
            chk("cmd_ready", 32'(cmd_ready), 32'(q.size() == 0));
            chk("busy", 32'(busy), 32'(q.size() != 0 || active));
            err_flag = 1'b0;
            if (cmd_valid && q.size() == 0) begin
                case (cmd_op)
                    2'b00: push(cmd_rs, 1'b0, cmd_data, 1'b0);
                    2'b01: push(cmd_rs, 1'b1, 8'h00, 1'b1);
`ifdef GFX_BRIDGE_PUTCHAR_EN
                    2'b10: begin
                        push(4'd3, 1'b0, cmd_addr[7:0], 1'b0);
                        push(4'd4, 1'b0, cmd_addr[15:8], 1'b0);
                        push(4'd1, 1'b0, cmd_data, 1'b0);
                    end
`endif
                    default: err_flag = 1'b1;
                endcase
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] rs, input logic [7:0] d,
                        input logic [15:0] a, input bit keep);
        int n = 0;
        cmd_op = op; cmd_rs = rs; cmd_data = d; cmd_addr = a; cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 64);
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: cmd_ready got 0 expected 1 within 64 clk");
        end
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  rs;
        logic [7:0]  data;
        logic [15:0] addr;
        int          din;
        int          launches;
        int          errs;
        int          rsps;
        logic [7:0]  rsp;
    } vec_t;

    vec_t tbl[6];
    int   nl, ne, nr;
    bit   found;

    initial begin
        tbl[0] = '{2'b00, 4'h3, 8'h5A, 16'h0000, -1,    1, 0, 0, 8'h00};
        tbl[1] = '{2'b01, 4'h2, 8'h00, 16'h0000, 8'hC3, 1, 0, 1, 8'hC3};
`ifdef GFX_BRIDGE_PUTCHAR_EN
        tbl[2] = '{2'b10, 4'h0, 8'h41, 16'h1234, -1,    3, 0, 0, 8'h00};
`else
        tbl[2] = '{2'b10, 4'h0, 8'h41, 16'h1234, -1,    0, 1, 0, 8'h00};
`endif
        tbl[3] = '{2'b11, 4'h5, 8'h77, 16'hFFFF, -1,    0, 1, 0, 8'h00};
        tbl[4] = '{2'b01, 4'hF, 8'h00, 16'h0000, 8'h00, 1, 0, 1, 8'h00};
        tbl[5] = '{2'b00, 4'h0, 8'hFF, 16'h0000, -1,    1, 0, 0, 8'h00};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        foreach (tbl[i]) begin
            fixed_din = tbl[i].din;
            nl = n_launch; ne = n_err; nr = n_rsp;
            send(tbl[i].op, tbl[i].rs, tbl[i].data, tbl[i].addr, 1'b0);
            idle(5 * P);
            chk($sformatf("vec%0d_launches", i), 32'(n_launch - nl), 32'(tbl[i].launches));
            chk($sformatf("vec%0d_errs", i), 32'(n_err - ne), 32'(tbl[i].errs));
            chk($sformatf("vec%0d_rsps", i), 32'(n_rsp - nr), 32'(tbl[i].rsps));
            if (tbl[i].rsps != 0) chk($sformatf("vec%0d_rsp_data", i), 32'(last_rsp), 32'(tbl[i].rsp));
        end
        fixed_din = -1;

        // two writes with cmd_valid held: second launches on the very next bus period
        nl = n_launch;
        send(2'b00, 4'h1, 8'h11, 16'h0, 1'b1);
        send(2'b00, 4'h1, 8'h22, 16'h0, 1'b0);
        idle(4 * P);
        chk("b2b_launches", 32'(n_launch - nl), 32'd2);
        chk("b2b_last_data", 32'(bus_data_o), 32'h22);

        // reset during the high phase of a write
        send(2'b00, 4'h6, 8'hA5, 16'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            found = bus_clk && !bus_cs_n;
        end
        chk("rst_reach_high", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_cs_n", 32'(bus_cs_n), 32'd1);
        chk("rst_async_oe", 32'(bus_data_oe), 32'd0);
        chk("rst_async_bus_clk", 32'(bus_clk), 32'd0);
        idle(3);
        rst_n = 1'b1;
        nl = n_launch;
        idle(4 * P);
        chk("rst_no_stale_cycle", 32'(n_launch - nl), 32'd0);

        for (int i = 0; i < 80; i++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                idle($urandom_range(0, 12));
            end
        end
        cmd_valid = 1'b0;
        idle(5 * P);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
